// File: rtl/uart_hex_sender_if.sv
// Purpose: bundles the word handshake and the transmitter-side character interface.
// Ports  : i_word/i_valid/o_ready (word in), o_data/o_txen/i_txempty (to transmitter),
//          o_busy/o_done (status). slave = formatter side, master = driver/transmitter side.
interface uart_hex_sender_if #(
  parameter int NIBBLES = 4
);
  logic [4*NIBBLES-1:0] i_word;
  logic                 i_valid;
  logic                 o_ready;
  logic [7:0]           o_data;
  logic                 o_txen;
  logic                 i_txempty;
  logic                 o_busy;
  logic                 o_done;

  modport slave (
    input  i_word, i_valid, i_txempty,
    output o_ready, o_data, o_txen, o_busy, o_done
  );

  modport master (
    output i_word, i_valid, i_txempty,
    input  o_ready, o_data, o_txen, o_busy, o_done
  );
endinterface

// File: rtl/uart_hex_sender.sv
// Purpose: prints a binary word as uppercase ASCII hex (MSB nibble first), optional CR LF.
// Ports  : i_clk, i_rst (sync, active-high), bus (uart_hex_sender_if.slave).
// Flow   : one o_txen pulse per character, issued only while i_txempty=1; o_ready only in IDLE.
module uart_hex_sender #(
  parameter int NIBBLES   = 4,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_hex_sender_if.slave   bus
);

  localparam int NCHAR = NIBBLES + 2 * int'(SEND_CRLF);
  localparam int IDXW  = $clog2(NCHAR + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [4*NIBBLES-1:0] r_word;
  logic [IDXW-1:0]      r_idx;
  logic [3:0]           w_nib;
  logic [7:0]           w_char;
  logic                 w_last;

  assign w_last = (r_idx == IDXW'(NCHAR - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Word and character index; idx only advances once the previous character has left the
  // transmitter, so it always points at the character currently being offered or sent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (r_state == S_IDLE && bus.i_valid) begin
      r_word <= bus.i_word;
      r_idx  <= '0;
    end else if (r_state == S_WAIT && bus.i_txempty && !w_last) begin
      r_idx  <= r_idx + IDXW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_valid) w_next = S_SEND;
      S_SEND:  if (bus.i_txempty) w_next = S_WAIT;
      S_WAIT:  if (bus.i_txempty) w_next = w_last ? S_IDLE : S_SEND;
      default: w_next = S_IDLE;
    endcase
  end

  // Nibble select, MSB nibble at idx 0
  always_comb begin
    w_nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDXW'(k)) w_nib = r_word[4*(NIBBLES-1-k) +: 4];
    end
  end

  // ASCII mapping: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37)
  always_comb begin
    w_char = 8'h0A;
    if (r_idx < IDXW'(NIBBLES)) begin
      w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
    end else if (r_idx == IDXW'(NIBBLES)) begin
      w_char = 8'h0D;
    end
  end

  // Outputs; o_txen is suppressed during reset so no character escapes while resetting.
  always_comb begin
    bus.o_ready = (r_state == S_IDLE);
    bus.o_busy  = (r_state != S_IDLE);
    bus.o_txen  = (r_state == S_SEND) && bus.i_txempty && !i_rst;
    bus.o_done  = (r_state == S_WAIT) && bus.i_txempty && w_last;
    bus.o_data  = w_char;
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
module tb_uart_hex_sender;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_hex_sender_if #(.NIBBLES(4)) ifa ();
  uart_hex_sender_if #(.NIBBLES(2)) ifb ();

  uart_hex_sender #(.NIBBLES(4), .SEND_CRLF(1'b1)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  uart_hex_sender #(.NIBBLES(2), .SEND_CRLF(1'b0)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Transmitter models: empty drops the cycle after capture, busy for char_cycles clocks.
  int   char_cycles = 870;
  int   cnt_a = 0;
  int   cnt_b = 0;
  logic hold_a = 1'b0;

  always @(posedge clk) begin
    if (ifa.o_txen && ifa.i_txempty) cnt_a <= char_cycles;
    else if (cnt_a > 0)              cnt_a <= cnt_a - 1;
    if (ifb.o_txen && ifb.i_txempty) cnt_b <= char_cycles;
    else if (cnt_b > 0)              cnt_b <= cnt_b - 1;
  end

  assign ifa.i_txempty = (cnt_a == 0) && !hold_a;
  assign ifb.i_txempty = (cnt_b == 0);

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int pulses_a = 0, pulses_b = 0;
  int since_a = 0, since_b = 0;
  string hexs = "0123456789ABCDEF";

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return hexs[int'(n)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) exp_a.push_back(hexc(w[4*i +: 4]));
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  // Scoreboard monitor for the 4-digit CR LF instance
  task automatic mon_a();
    logic       prev_txen = 1'b0;
    logic       prev_empty = 1'b1;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) since_a = 0;
      if (ifa.o_txen) begin
        pulses_a++;
        since_a++;
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_char_unexpected: got %h, expected no character", ifa.o_data);
        end else begin
          e = exp_a.pop_front();
          if (ifa.o_data !== e) begin
            errors++;
            $display("FAIL a_char: got %h, expected %h", ifa.o_data, e);
          end
        end
        checks++;
        if (prev_txen) begin
          errors++;
          $display("FAIL a_txen_consecutive: txen high 2 cycles, expected single pulse");
        end
        checks++;
        if (cnt_a != 0 || hold_a) begin
          errors++;
          $display("FAIL a_txen_overlap: txen with transmitter busy (cnt=%0d hold=%0b), expected idle", cnt_a, hold_a);
        end
      end
      if (ifa.o_done) begin
        checks++;
        if (since_a != 6 || !ifa.i_txempty || prev_empty) begin
          errors++;
          $display("FAIL a_done_timing: chars=%0d empty=%0b prev_empty=%0b, expected 6/1/0", since_a, ifa.i_txempty, prev_empty);
        end
        since_a = 0;
      end
      prev_txen  = ifa.o_txen;
      prev_empty = ifa.i_txempty;
    end
  endtask

  // Scoreboard monitor for the 2-digit no-CRLF instance
  task automatic mon_b();
    logic       prev_txen = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) since_b = 0;
      if (ifb.o_txen) begin
        pulses_b++;
        since_b++;
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_char_unexpected: got %h, expected no character", ifb.o_data);
        end else begin
          e = exp_b.pop_front();
          if (ifb.o_data !== e) begin
            errors++;
            $display("FAIL b_char: got %h, expected %h", ifb.o_data, e);
          end
        end
        checks++;
        if (prev_txen || cnt_b != 0) begin
          errors++;
          $display("FAIL b_txen_overlap: prev_txen=%0b cnt=%0d, expected 0/0", prev_txen, cnt_b);
        end
      end
      if (ifb.o_done) begin
        checks++;
        if (since_b != 2 || !ifb.i_txempty) begin
          errors++;
          $display("FAIL b_done_timing: chars=%0d empty=%0b, expected 2/1", since_b, ifb.i_txempty);
        end
        since_b = 0;
      end
      prev_txen = ifb.o_txen;
    end
  endtask

  task automatic send_a(input logic [15:0] w);
    int n = 0;
    while (!ifa.o_ready && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (!ifa.o_ready) begin
      errors++;
      $display("FAIL a_ready_timeout: ready=0, expected 1 within bound");
    end
    ifa.i_word  = w;
    ifa.i_valid = 1'b1;
    tick();
    ifa.i_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    int n = 0;
    @(negedge clk);
    while (!ifa.o_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ifa.o_done) begin
      errors++;
      $display("FAIL a_done_timeout: done=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic test_reset();
    ifa.i_word = '0; ifa.i_valid = 1'b0;
    ifb.i_word = '0; ifb.i_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (ifa.o_txen !== 1'b0) begin
      errors++;
      $display("FAIL reset_txen_forced: got %b, expected 0", ifa.o_txen);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifa.o_ready, ifa.o_busy, ifa.o_done, ifa.o_txen} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: ready/busy/done/txen=%b, expected 1000",
               {ifa.o_ready, ifa.o_busy, ifa.o_done, ifa.o_txen});
    end
    checks++;
    if ({ifb.o_ready, ifb.o_busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_state_b: ready/busy=%b, expected 10", {ifb.o_ready, ifb.o_busy});
    end
  endtask

  task automatic test_single();
    int base = pulses_a;
    char_cycles = 870;
    tick();
    push_a(16'h1A3F);
    send_a(16'h1A3F);
    wait_done_a(8000);
    @(negedge clk);
    checks++;
    if (pulses_a - base != 6) begin
      errors++;
      $display("FAIL single_pulses: got %0d, expected 6", pulses_a - base);
    end
    checks++;
    if (ifa.o_ready !== 1'b1 || ifa.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_after: ready=%b busy=%b, expected 1/0", ifa.o_ready, ifa.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base = pulses_a;
    int n = 0;
    char_cycles = 20;
    push_a(16'h0000);
    push_a(16'hFFFF);
    tick();
    ifa.i_word  = 16'h0000;
    ifa.i_valid = 1'b1;
    @(negedge clk);
    while (!ifa.o_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    tick();
    ifa.i_word = 16'hFFFF;
    wait_done_a(1000);
    checks++;
    if (ifa.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_in_done: got %b, expected 0", ifa.o_ready);
    end
    @(negedge clk);
    checks++;
    if (ifa.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_after_done: got %b, expected 1", ifa.o_ready);
    end
    @(negedge clk);
    checks++;
    if (ifa.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b, expected 1", ifa.o_busy);
    end
    wait_done_a(1000);
    ifa.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pulses_a - base != 12 || ifa.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d busy=%b, expected 12 busy=0", pulses_a - base, ifa.o_busy);
    end
  endtask

  task automatic test_stall();
    char_cycles = 20;
    hold_a = 1'b1;
    push_a(16'h5C07);
    send_a(16'h5C07);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.o_txen !== 1'b0 || ifa.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: txen=%b busy=%b, expected 0/1", i, ifa.o_txen, ifa.o_busy);
      end
    end
    tick();
    hold_a = 1'b0;
    @(negedge clk);
    checks++;
    if (ifa.o_txen !== 1'b1 || ifa.o_data !== 8'h35) begin
      errors++;
      $display("FAIL stall_release: txen=%b data=%h, expected 1/35", ifa.o_txen, ifa.o_data);
    end
    wait_done_a(1000);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int n = 0;
    int base;
    char_cycles = 20;
    tick();
    exp_a.push_back(8'h42);
    exp_a.push_back(8'h45);
    exp_a.push_back(8'h45);
    send_a(16'hBEEF);
    while (seen < 3 && n < 1000) begin
      @(negedge clk);
      if (ifa.o_txen) seen++;
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifa.o_busy, ifa.o_ready, ifa.o_txen} !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_state: busy/ready/txen=%b, expected 010",
               {ifa.o_busy, ifa.o_ready, ifa.o_txen});
    end
    base = pulses_a;
    repeat (60) @(negedge clk);
    checks++;
    if (pulses_a != base) begin
      errors++;
      $display("FAIL reset_mid_abandon: %0d extra pulses, expected 0", pulses_a - base);
    end
    tick();
    push_a(16'h00A5);
    send_a(16'h00A5);
    wait_done_a(1000);
  endtask

  task automatic test_nib2();
    int base = pulses_b;
    int n = 0;
    char_cycles = 20;
    tick();
    exp_b.push_back(8'h46);
    exp_b.push_back(8'h30);
    ifb.i_word  = 8'hF0;
    ifb.i_valid = 1'b1;
    tick();
    ifb.i_valid = 1'b0;
    @(negedge clk);
    while (!ifb.o_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ifb.o_done) begin
      errors++;
      $display("FAIL nib2_done_timeout: done=0, expected 1");
    end
    @(negedge clk);
    checks++;
    if (pulses_b - base != 2 || ifb.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL nib2_pulses: got %0d ready=%b, expected 2 ready=1", pulses_b - base, ifb.o_ready);
    end
  endtask

  task automatic test_sweep();
    char_cycles = 3;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = {4'(i), 12'h000};
      push_a(w);
      send_a(w);
      wait_done_a(500);
    end
    tick();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d left, expected 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  initial begin
    fork
      mon_a();
      mon_b();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_nib2();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
